// File: rtl/pipeline_pkg.sv
// Shared types and constants for the ID/EX operand fetch path of the 64-bit datapath.
// Holds the operand forwarding helpers used by both operand muxes.
package pipeline_pkg;

    localparam int DATA_W = 64;
    localparam int REG_W  = 5;
    localparam int CNT_W  = 16;

    localparam logic [REG_W-1:0] ZERO_REG = REG_W'(31);

    // Contents of the ID/EX pipeline register
    typedef struct packed {
        logic [DATA_W-1:0] a;
        logic [DATA_W-1:0] b;
        logic [REG_W-1:0]  rd;
        logic              regwrite;
        logic              memread;
    } idex_t;

    // One bypass source as seen from the operand stage
    typedef struct packed {
        logic              valid;
        logic              regwrite;
        logic [REG_W-1:0]  rd;
        logic [DATA_W-1:0] data;
    } fwd_t;

    typedef enum logic [2:0] {
        SRC_ZERO,
        SRC_EX,
        SRC_MEM,
        SRC_WB,
        SRC_RF
    } src_sel_e;

    // XZR is never a producer, so a write aimed at it must not forward
    function automatic logic fwd_hit(input fwd_t f, input logic [REG_W-1:0] idx);
        return f.valid && f.regwrite && (f.rd != ZERO_REG) && (f.rd == idx);
    endfunction

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == {CNT_W{1'b1}}) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/operand_fwd_mux.sv
// Priority operand select for one source index: XZR, then EX, MEM, WB bypass,
// and finally the register-file read data.
module operand_fwd_mux
    import pipeline_pkg::*;
(
    input  logic [REG_W-1:0]  idx_i,
    input  logic [DATA_W-1:0] rf_data_i,
    input  fwd_t              ex_i,
    input  fwd_t              mem_i,
    input  fwd_t              wb_i,
    output logic [DATA_W-1:0] data_o
);

    src_sel_e sel;

    // Younger producers win; WB covers the write-through gap of the register file
    always_comb begin
        sel = SRC_RF;
        if (idx_i == ZERO_REG) begin
            sel = SRC_ZERO;
        end else if (fwd_hit(ex_i, idx_i)) begin
            sel = SRC_EX;
        end else if (fwd_hit(mem_i, idx_i)) begin
            sel = SRC_MEM;
        end else if (fwd_hit(wb_i, idx_i)) begin
            sel = SRC_WB;
        end
    end

    always_comb begin
        data_o = rf_data_i;
        case (sel)
            SRC_ZERO: data_o = '0;
            SRC_EX:   data_o = ex_i.data;
            SRC_MEM:  data_o = mem_i.data;
            SRC_WB:   data_o = wb_i.data;
            default:  data_o = rf_data_i;
        endcase
    end

endmodule

// File: rtl/operand_fetch_stage.sv
// Decode-to-execute operand stage: register-file addressing, bypass selection,
// load-use stall and the ID/EX register behind a valid/ready handshake.
module operand_fetch_stage
    import pipeline_pkg::*;
(
    input  logic              clk_i,
    input  logic              reset_ni,

    input  logic              in_valid_i,
    output logic              in_ready_o,
    input  logic [REG_W-1:0]  in_rn_i,
    input  logic [REG_W-1:0]  in_rm_i,
    input  logic [REG_W-1:0]  in_rd_i,
    input  logic              in_regwrite_i,
    input  logic              in_memread_i,

    output logic [REG_W-1:0]  rf_rr1_o,
    output logic [REG_W-1:0]  rf_rr2_o,
    input  logic [DATA_W-1:0] rf_rd1_i,
    input  logic [DATA_W-1:0] rf_rd2_i,

    input  logic              ex_valid_i,
    input  logic              ex_regwrite_i,
    input  logic [REG_W-1:0]  ex_rd_i,
    input  logic [DATA_W-1:0] ex_result_i,

    input  logic              mem_valid_i,
    input  logic              mem_regwrite_i,
    input  logic [REG_W-1:0]  mem_rd_i,
    input  logic [DATA_W-1:0] mem_result_i,

    input  logic              wb_regwrite_i,
    input  logic [REG_W-1:0]  wb_rd_i,
    input  logic [DATA_W-1:0] wb_data_i,

    input  logic              flush_i,

    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic [DATA_W-1:0] out_a_o,
    output logic [DATA_W-1:0] out_b_o,
    output logic [REG_W-1:0]  out_rd_o,
    output logic              out_regwrite_o,
    output logic              out_memread_o,
    output logic [CNT_W-1:0]  bubble_count_o
);

    fwd_t ex_fwd;
    fwd_t mem_fwd;
    fwd_t wb_fwd;

    logic [DATA_W-1:0] op_a;
    logic [DATA_W-1:0] op_b;

    idex_t            idex_q, idex_d;
    logic             out_valid_q, out_valid_d;
    logic [CNT_W-1:0] bubble_q, bubble_d;

    logic hazard;
    logic in_ready;

    assign rf_rr1_o = in_rn_i;
    assign rf_rr2_o = in_rm_i;

    // The WB write lands this edge, so it is always a live producer
    assign ex_fwd  = '{valid: ex_valid_i,  regwrite: ex_regwrite_i,  rd: ex_rd_i,  data: ex_result_i};
    assign mem_fwd = '{valid: mem_valid_i, regwrite: mem_regwrite_i, rd: mem_rd_i, data: mem_result_i};
    assign wb_fwd  = '{valid: 1'b1,        regwrite: wb_regwrite_i,  rd: wb_rd_i,  data: wb_data_i};

    operand_fwd_mux u_fwd_a (
        .idx_i     (in_rn_i),
        .rf_data_i (rf_rd1_i),
        .ex_i      (ex_fwd),
        .mem_i     (mem_fwd),
        .wb_i      (wb_fwd),
        .data_o    (op_a)
    );

    operand_fwd_mux u_fwd_b (
        .idx_i     (in_rm_i),
        .rf_data_i (rf_rd2_i),
        .ex_i      (ex_fwd),
        .mem_i     (mem_fwd),
        .wb_i      (wb_fwd),
        .data_o    (op_b)
    );

    // A load sitting in ID/EX cannot feed the next instruction until it reaches MEM
    assign hazard = out_valid_q && idex_q.memread && (idex_q.rd != ZERO_REG) &&
                    ((idex_q.rd == in_rn_i) || (idex_q.rd == in_rm_i)) && in_valid_i;

    assign in_ready = !flush_i && !hazard && (!out_valid_q || out_ready_i);

    // Holding under backpressure is the default: nothing below fires while stalled
    always_comb begin
        idex_d      = idex_q;
        out_valid_d = out_valid_q;
        bubble_d    = bubble_q;
        if (flush_i) begin
            out_valid_d     = 1'b0;
            idex_d.regwrite = 1'b0;
            idex_d.memread  = 1'b0;
        end else if (in_valid_i && in_ready) begin
            idex_d.a        = op_a;
            idex_d.b        = op_b;
            idex_d.rd       = in_rd_i;
            idex_d.regwrite = in_regwrite_i;
            idex_d.memread  = in_memread_i;
            out_valid_d     = 1'b1;
        end else if (hazard && out_ready_i) begin
            out_valid_d     = 1'b0;
            idex_d.regwrite = 1'b0;
            idex_d.memread  = 1'b0;
            bubble_d        = sat_inc(bubble_q);
        end else if (out_ready_i && !in_valid_i) begin
            out_valid_d     = 1'b0;
            idex_d.regwrite = 1'b0;
            idex_d.memread  = 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!reset_ni) begin
            idex_q.a        <= '0;
            idex_q.b        <= '0;
            idex_q.rd       <= ZERO_REG;
            idex_q.regwrite <= 1'b0;
            idex_q.memread  <= 1'b0;
            out_valid_q     <= 1'b0;
            bubble_q        <= '0;
        end else begin
            idex_q      <= idex_d;
            out_valid_q <= out_valid_d;
            bubble_q    <= bubble_d;
        end
    end

    assign in_ready_o     = in_ready;
    assign out_valid_o    = out_valid_q;
    assign out_a_o        = idex_q.a;
    assign out_b_o        = idex_q.b;
    assign out_rd_o       = idex_q.rd;
    assign out_regwrite_o = idex_q.regwrite;
    assign out_memread_o  = idex_q.memread;
    assign bubble_count_o = bubble_q;

endmodule

// File: tb/tb_operand_fetch_stage.sv
// Directed and randomized checks of operand_fetch_stage against a rule-level model
// of operand selection, load-use stalling and the ID/EX handshake.
module tb_operand_fetch_stage;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        in_valid, in_ready;
    logic [4:0]  in_rn, in_rm, in_rd;
    logic        in_regwrite, in_memread;
    logic [4:0]  rf_rr1, rf_rr2;
    logic [63:0] rf_rd1, rf_rd2;
    logic        ex_valid, ex_regwrite;
    logic [4:0]  ex_rd;
    logic [63:0] ex_result;
    logic        mem_valid, mem_regwrite;
    logic [4:0]  mem_rd;
    logic [63:0] mem_result;
    logic        wb_regwrite;
    logic [4:0]  wb_rd;
    logic [63:0] wb_data;
    logic        flush;
    logic        out_valid, out_ready;
    logic [63:0] out_a, out_b;
    logic [4:0]  out_rd;
    logic        out_regwrite, out_memread;
    logic [15:0] bubble_count;

    int errors = 0;
    int checks = 0;

    // Expected architectural state of the ID/EX register
    logic        m_valid;
    logic [63:0] m_a, m_b;
    logic [4:0]  m_rd;
    logic        m_rw, m_mr;
    logic [15:0] m_bub;
    bit          m_ctrl_known;
    bit          m_post_reset;

    always #5 clk = ~clk;

    operand_fetch_stage dut (
        .clk_i          (clk),
        .reset_ni       (reset_n),
        .in_valid_i     (in_valid),
        .in_ready_o     (in_ready),
        .in_rn_i        (in_rn),
        .in_rm_i        (in_rm),
        .in_rd_i        (in_rd),
        .in_regwrite_i  (in_regwrite),
        .in_memread_i   (in_memread),
        .rf_rr1_o       (rf_rr1),
        .rf_rr2_o       (rf_rr2),
        .rf_rd1_i       (rf_rd1),
        .rf_rd2_i       (rf_rd2),
        .ex_valid_i     (ex_valid),
        .ex_regwrite_i  (ex_regwrite),
        .ex_rd_i        (ex_rd),
        .ex_result_i    (ex_result),
        .mem_valid_i    (mem_valid),
        .mem_regwrite_i (mem_regwrite),
        .mem_rd_i       (mem_rd),
        .mem_result_i   (mem_result),
        .wb_regwrite_i  (wb_regwrite),
        .wb_rd_i        (wb_rd),
        .wb_data_i      (wb_data),
        .flush_i        (flush),
        .out_valid_o    (out_valid),
        .out_ready_i    (out_ready),
        .out_a_o        (out_a),
        .out_b_o        (out_b),
        .out_rd_o       (out_rd),
        .out_regwrite_o (out_regwrite),
        .out_memread_o  (out_memread),
        .bubble_count_o (bubble_count)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Operand value by the architectural rules, youngest producer first
    function automatic logic [63:0] refOperand(input logic [4:0] idx, input logic [63:0] rf);
        if (idx == 5'd31) return 64'd0;
        if (ex_valid && ex_regwrite && ex_rd == idx) return ex_result;
        if (mem_valid && mem_regwrite && mem_rd == idx) return mem_result;
        if (wb_regwrite && wb_rd == idx) return wb_data;
        return rf;
    endfunction

    task automatic clearInputs();
        in_valid = 0; in_rn = 0; in_rm = 0; in_rd = 0; in_regwrite = 0; in_memread = 0;
        rf_rd1 = 0; rf_rd2 = 0;
        ex_valid = 0; ex_regwrite = 0; ex_rd = 0; ex_result = 0;
        mem_valid = 0; mem_regwrite = 0; mem_rd = 0; mem_result = 0;
        wb_regwrite = 0; wb_rd = 0; wb_data = 0;
        flush = 0; out_ready = 1;
    endtask

    task automatic checkOutput();
        chk("out_valid", 64'(out_valid), 64'(m_valid));
        chk("bubble_count", 64'(bubble_count), 64'(m_bub));
        if (m_valid || m_post_reset) begin
            chk("out_a", out_a, m_a);
            chk("out_b", out_b, m_b);
            chk("out_rd", 64'(out_rd), 64'(m_rd));
        end
        if (m_valid || m_ctrl_known) begin
            chk("out_regwrite", 64'(out_regwrite), 64'(m_rw));
            chk("out_memread", 64'(out_memread), 64'(m_mr));
        end
    endtask

    // Inputs are already driven; check combinational outputs, clock once, update model, compare
    task automatic applyStimulus();
        logic        hz, rdy;
        logic [63:0] ea, eb;
        #1;
        hz  = m_valid && m_mr && (m_rd != 5'd31) && ((m_rd == in_rn) || (m_rd == in_rm)) && in_valid;
        rdy = !flush && !hz && (!m_valid || out_ready);
        if (reset_n) chk("in_ready", 64'(in_ready), 64'(rdy));
        chk("rf_rr1", 64'(rf_rr1), 64'(in_rn));
        chk("rf_rr2", 64'(rf_rr2), 64'(in_rm));
        ea = refOperand(in_rn, rf_rd1);
        eb = refOperand(in_rm, rf_rd2);
        @(posedge clk);
        #1;
        m_post_reset = 0;
        if (!reset_n) begin
            m_valid = 0; m_a = 0; m_b = 0; m_rd = 5'd31; m_rw = 0; m_mr = 0; m_bub = 0;
            m_ctrl_known = 1; m_post_reset = 1;
        end else if (flush) begin
            m_valid = 0; m_rw = 0; m_mr = 0; m_ctrl_known = 1;
        end else if (in_valid && rdy) begin
            m_valid = 1; m_a = ea; m_b = eb; m_rd = in_rd; m_rw = in_regwrite; m_mr = in_memread;
            m_ctrl_known = 1;
        end else if (hz && out_ready) begin
            m_valid = 0; m_rw = 0; m_mr = 0; m_ctrl_known = 1;
            if (m_bub != 16'hFFFF) m_bub = m_bub + 16'd1;
        end else if (m_valid && !out_ready) begin
            m_valid = m_valid;
        end else if (out_ready && !in_valid) begin
            m_valid = 0; m_ctrl_known = 0;
        end
        checkOutput();
    endtask

    function automatic logic [4:0] rndIdx();
        return ($urandom_range(0, 9) == 0) ? 5'd31 : 5'($urandom_range(0, 7));
    endfunction

    initial begin
        m_valid = 0; m_a = 0; m_b = 0; m_rd = 5'd31; m_rw = 0; m_mr = 0; m_bub = 0;
        m_ctrl_known = 0; m_post_reset = 0;
        clearInputs();
        reset_n = 0;
        #2;
        applyStimulus();
        applyStimulus();
        reset_n = 1;

        // Independent operands straight from the register file
        in_valid = 1; in_rn = 1; in_rm = 2; in_rd = 4; in_regwrite = 1;
        rf_rd1 = 64'h11; rf_rd2 = 64'h22;
        applyStimulus();
        chk("indep_valid", 64'(out_valid), 64'd1);
        chk("indep_a", out_a, 64'h11);
        chk("indep_b", out_b, 64'h22);

        // Triple match, then peel off EX and MEM
        in_rn = 5; in_rm = 6; in_rd = 7;
        ex_valid = 1; ex_regwrite = 1; ex_rd = 5; ex_result = 64'hE;
        mem_valid = 1; mem_regwrite = 1; mem_rd = 5; mem_result = 64'hA;
        wb_regwrite = 1; wb_rd = 5; wb_data = 64'hB;
        applyStimulus();
        chk("triple_ex", out_a, 64'hE);
        ex_valid = 0;
        applyStimulus();
        chk("triple_mem", out_a, 64'hA);
        mem_valid = 0;
        applyStimulus();
        chk("triple_wb", out_a, 64'hB);
        wb_regwrite = 0;

        // XZR reads zero even with a matching EX write
        in_rn = 31; ex_valid = 1; ex_regwrite = 1; ex_rd = 31; ex_result = 64'hFF;
        applyStimulus();
        chk("xzr_a", out_a, 64'd0);
        ex_valid = 0; ex_regwrite = 0;

        // Load-use: one bubble, then the MEM bypass delivers the loaded value
        in_rn = 1; in_rm = 2; in_rd = 3; in_regwrite = 1; in_memread = 1;
        applyStimulus();
        in_rn = 4; in_rm = 3; in_rd = 5; in_memread = 0;
        #1;
        chk("lu_in_ready_low", 64'(in_ready), 64'd0);
        applyStimulus();
        chk("lu_bubble_valid", 64'(out_valid), 64'd0);
        chk("lu_bubble_count", 64'(bubble_count), 64'd1);
        mem_valid = 1; mem_regwrite = 1; mem_rd = 3; mem_result = 64'h77;
        #1;
        chk("lu_in_ready_high", 64'(in_ready), 64'd1);
        applyStimulus();
        chk("lu_fwd_b", out_b, 64'h77);
        chk("lu_fwd_valid", 64'(out_valid), 64'd1);
        mem_valid = 0; mem_regwrite = 0;

        // Backpressure for three cycles, then flush
        in_rn = 6; in_rm = 7; in_rd = 9; rf_rd1 = 64'h1234; rf_rd2 = 64'h5678;
        applyStimulus();
        out_ready = 0;
        for (int i = 0; i < 3; i++) begin
            in_rn = 5'(i); in_rm = 5'(i + 1); rf_rd1 = 64'(i); rf_rd2 = 64'(i);
            #1;
            chk("bp_in_ready", 64'(in_ready), 64'd0);
            applyStimulus();
            chk("bp_hold_a", out_a, 64'h1234);
            chk("bp_hold_b", out_b, 64'h5678);
        end
        flush = 1;
        applyStimulus();
        chk("flush_valid", 64'(out_valid), 64'd0);
        flush = 0; out_ready = 1;

        // Reset while an instruction is in flight
        applyStimulus();
        chk("pre_reset_valid", 64'(out_valid), 64'd1);
        reset_n = 0;
        applyStimulus();
        chk("rst_valid", 64'(out_valid), 64'd0);
        chk("rst_a", out_a, 64'd0);
        chk("rst_b", out_b, 64'd0);
        chk("rst_rd", 64'(out_rd), 64'd31);
        chk("rst_regwrite", 64'(out_regwrite), 64'd0);
        chk("rst_memread", 64'(out_memread), 64'd0);
        chk("rst_bubbles", 64'(bubble_count), 64'd0);
        reset_n = 1;
        #1;
        chk("rst_release_ready", 64'(in_ready), 64'd1);
        applyStimulus();

        // Randomized traffic against the model
        for (int n = 0; n < 400; n++) begin
            reset_n      = ($urandom_range(0, 63) != 0);
            in_valid     = ($urandom_range(0, 3) != 0);
            in_rn        = rndIdx();
            in_rm        = rndIdx();
            in_rd        = rndIdx();
            in_regwrite  = 1'($urandom);
            in_memread   = ($urandom_range(0, 2) == 0);
            rf_rd1       = {$urandom, $urandom};
            rf_rd2       = {$urandom, $urandom};
            ex_valid     = 1'($urandom);
            ex_regwrite  = 1'($urandom);
            ex_rd        = rndIdx();
            ex_result    = {$urandom, $urandom};
            mem_valid    = 1'($urandom);
            mem_regwrite = 1'($urandom);
            mem_rd       = rndIdx();
            mem_result   = {$urandom, $urandom};
            wb_regwrite  = 1'($urandom);
            wb_rd        = rndIdx();
            wb_data      = {$urandom, $urandom};
            flush        = ($urandom_range(0, 9) == 0);
            out_ready    = ($urandom_range(0, 3) != 0);
            applyStimulus();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
